// File: rtl/mem_port_arbiter_rr4.sv
// mem_port_arbiter_rr4
// Four-requester round-robin arbiter for the shared data-memory/bus port.
// One requester owns the port at a time. Ownership ends on the owner's
// done, when the owner drops its request, or when the hold limit expires.
// Every grant is followed by exactly one idle cycle, which gives the bus
// time to turn around.
//
// Parameters:
//   MAX_HOLD   maximum consecutive grant cycles per ownership (0 = no limit)
// Ports:
//   clk_i      rising-edge clock
//   rst_i      synchronous active-high reset
//   req_i      per-requester request, held high until served
//   done_i     per-requester release; only the current owner's bit is used
//   gnt_en_o   registered grant-active flag (decoder EN)
//   gnt_idx_o  registered owner index (decoder S); holds its value when idle
//   gnt_o      registered one-hot grant vector
//   timeout_o  registered one-cycle pulse when a grant is cut by MAX_HOLD
module mem_port_arbiter_rr4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] req_i,
  input  logic [3:0] done_i,
  output logic       gnt_en_o,
  output logic [1:0] gnt_idx_o,
  output logic [3:0] gnt_o,
  output logic       timeout_o
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // The hold counter starts at 0 on the grant edge, so the grant has been
  // visible for MAX_HOLD cycles when the counter reaches MAX_HOLD-1.
  localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST    = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       gnt_en_q, gnt_en_d;
  logic [1:0] gnt_idx_q, gnt_idx_d;
  logic [3:0] gnt_q, gnt_d;
  logic       timeout_q, timeout_d;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       rel_done;
  logic       rel_drop;
  logic       expired;

  // Rotating-priority search: start at ptr and walk upward mod 4, keeping
  // the first requester seen. The 2-bit add wraps 3 -> 0 for free.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Release conditions for the current owner. Foreign done bits never reach
  // this logic because only the owner's bit is selected.
  always_comb begin
    rel_done = done_i[gnt_idx_q];
    rel_drop = !req_i[gnt_idx_q];
    expired  = HOLD_LIMITED && (cnt_q == HOLD_LAST);
  end

  // Next-state and output logic. Outputs hold their value unless a grant
  // starts or ends; timeout is a pulse, so it defaults low every cycle.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_en_d  = gnt_en_q;
    gnt_idx_d = gnt_idx_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i != 4'b0000) begin
          state_d   = GRANT;
          gnt_idx_d = winner;
          gnt_en_d  = 1'b1;
          gnt_d     = 4'b0001 << winner;
          cnt_d     = 8'd0;
          ptr_d     = winner + 2'd1;
        end
      end
      GRANT: begin
        if (rel_done || rel_drop || expired) begin
          state_d   = IDLE;
          gnt_en_d  = 1'b0;
          gnt_d     = 4'b0000;
          timeout_d = expired && !rel_done && !rel_drop;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset mid-grant simply drops
  // the grant and never raises timeout.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      cnt_q     <= 8'd0;
      gnt_en_q  <= 1'b0;
      gnt_idx_q <= 2'd0;
      gnt_q     <= 4'b0000;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_en_q  <= gnt_en_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_q     <= gnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_en_o  = gnt_en_q;
  assign gnt_idx_o = gnt_idx_q;
  assign gnt_o     = gnt_q;
  assign timeout_o = timeout_q;

endmodule

// File: doc/mem_port_arbiter_rr4.md
# mem_port_arbiter_rr4

Four-requester round-robin arbiter for the shared data-memory/bus port of the pipelined processor. It chooses one requester at a time and holds that grant until the owner releases it or a hold limit expires. It then drives a registered 2-bit grant index plus enable, which feed the 2-to-4 grant decoder (EN, S) and the port's address/data mux select. The block owns fairness, hold-time bounding and bus turnaround sequencing; the datapath itself stays combinational.

## Interface
- MAX_HOLD, default 8: maximum consecutive GRANT cycles per ownership; 0 disables the limit; legal range 0..255.
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  req[i] high = requester i wants the port; level-held until served.
- done  input  4  done[i] high = requester i releases the port this cycle; honoured only for the current owner.
- gnt_en  output  1  registered; high while a grant is active (drives decoder EN).
- gnt_idx  output  2  registered; index of the current owner (drives decoder S); holds its last value when gnt_en is low.
- gnt  output  4  registered one-hot; gnt[gnt_idx] = gnt_en; all zero when idle.
- timeout  output  1  registered one-cycle pulse; the current grant was force-ended by MAX_HOLD.

## Operation
- States: IDLE, GRANT. Hold counter: 8 bits. Priority pointer ptr: 2 bits.
- Reset: state=IDLE, ptr=0, cnt=0, gnt_en=0, gnt_idx=0, gnt=0000, timeout=0. Reset overrides everything; asserting rst mid-grant drops gnt_en at that edge with no timeout pulse.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first i with req[i]=1, scanning ptr, ptr+1, … mod 4 (wraps 3→0).
  - Next edge: state=GRANT, gnt_idx=winner, gnt_en=1, gnt=onehot(winner), cnt=0, ptr=winner+1 mod 4.
- GRANT, with owner o=gnt_idx. The grant ends when any of these holds:
  - (a) done[o]=1
  - (b) req[o]=0
  - (c) MAX_HOLD≠0 and cnt==MAX_HOLD-1
- GRANT, end of grant: next edge gives state=IDLE, gnt_en=0, gnt=0000. timeout=1 only if (c) applied and (a) and (b) did not.
- GRANT, otherwise: cnt increments (saturating at 255) and all outputs hold.
- done[j] for j≠o is ignored in every state. done in IDLE is ignored.
- There is always exactly one IDLE cycle between successive grants (bus turnaround). This holds even if the same requester is still requesting.
- Fairness: after any grant to i, requester i has the lowest priority at the next arbitration. With all four requesting continuously, the grant order is 0,1,2,3,0,…
- timeout lasts exactly one cycle and coincides with the first IDLE cycle.

## Timing
- Request-to-grant latency: req rises in IDLE at edge t, so gnt_en=1 after edge t+1 (one cycle). If req rises during someone else's GRANT, the latency depends on that grant's release plus one turnaround cycle.
- Release: done[o] sampled at edge t, so gnt_en=0 after t; the earliest next grant is visible after t+1.
- Hold limit: the grant is visible for exactly MAX_HOLD cycles when neither done nor req-drop occurs first. Example: MAX_HOLD=1 gives a one-cycle grant.
- All outputs are registered; there is no combinational path from req or done to any output.
- Simultaneous done[o] and MAX_HOLD expiry: normal release, timeout=0.
- Simultaneous req changes during IDLE: the arbitration uses the req value sampled at that edge.

## Test plan
- Reset and single request:
  - Stimulus: rst for 2 cycles, then req=0100 with done[2] at the 3rd grant cycle.
  - Required: all outputs 0 during reset. After release of rst, gnt_en=1, gnt_idx=2 and gnt=0100 one cycle after req. Grant lasts 3 cycles, then gnt_en=0. ptr=3.
- Round-robin wrap:
  - Stimulus: req=1111 held, each owner pulses done in its first grant cycle.
  - Required: gnt_idx sequence 0,1,2,3,0,1, with one idle cycle between each grant.
- Hold limit:
  - Stimulus: MAX_HOLD=4, req=0011 held, no done.
  - Required: owner 0 is granted for 4 cycles, then timeout=1 for one cycle with gnt_en=0, then owner 1 is granted.
  - Also: MAX_HOLD=0 with no done keeps the grant indefinitely (check 300 cycles).
- Foreign done and req drop:
  - Stimulus: owner 1 granted; pulse done[3], then drop req[1].
  - Required: done[3] causes no change. The req[1] drop ends the grant at the next edge with timeout=0.
- Simultaneous events:
  - Stimulus: MAX_HOLD=2, done[o] asserted in the expiry cycle.
  - Required: grant ends, timeout stays 0.
- Reset mid-grant:
  - Stimulus: assert rst while gnt_en=1.
  - Required: outputs return to their reset values at that edge, timeout=0, and ptr=0 afterwards (req=1111 gives owner 0 first).
